// File: rtl/fb_arbiter_if.sv
// Frame-buffer arbiter bus: scanout read port, queued write port and memory port.
// slave = arbiter side, master = requesters plus memory.
interface fb_arbiter_if #(
  parameter int ADDR_W     = 15,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
) ();
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [LVL_W-1:0]  wr_level;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  rd_req, rd_addr, wr_req, wr_addr, wr_data, mem_rdata,
    output rd_valid, rd_data, wr_level, mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output rd_req, rd_addr, wr_req, wr_addr, wr_data, mem_rdata,
    input  rd_valid, rd_data, wr_level, mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/fb_arbiter.sv
// Frame-buffer arbiter: one single-port memory shared by scanout reads (absolute
// priority) and a FIFO of queued pixel writes. Optional drop counter: FB_ARBITER_DROP_CNT_EN.
module fb_arbiter #(
  parameter int ADDR_W     = 15,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input logic         clk,
  input logic         reset,
  fb_arbiter_if.slave bus
`ifdef FB_ARBITER_DROP_CNT_EN
  ,
  output logic [15:0] drop_cnt
`endif
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(FIFO_DEPTH);

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_depth_chk
    $error("fb_arbiter: FIFO_DEPTH must be a power of two and at least 2");
  end

  logic [ADDR_W-1:0] q_addr [FIFO_DEPTH];
  logic [DATA_W-1:0] q_data [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [LVL_W-1:0]  level;
  logic              pop;
  logic              push;
  logic              vld_p1;
  logic              vld_p2;

  // A pop frees a slot in the same cycle, so a full queue still accepts when draining.
  always_comb begin
    pop  = 1'b0;
    push = 1'b0;
    pop  = !bus.rd_req && (level != '0);
    push = bus.wr_req && (pop || (level != FULL_LVL));
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_addr[wr_ptr] <= bus.wr_addr;
      q_data[wr_ptr] <= bus.wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

  assign bus.wr_level = level;

  // Stage p0 -> p1: slot selection, registered memory command
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.mem_en    <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
    end else if (bus.rd_req) begin
      bus.mem_en   <= 1'b1;
      bus.mem_we   <= 1'b0;
      bus.mem_addr <= bus.rd_addr;
    end else if (pop) begin
      bus.mem_en    <= 1'b1;
      bus.mem_we    <= 1'b1;
      bus.mem_addr  <= q_addr[rd_ptr];
      bus.mem_wdata <= q_data[rd_ptr];
    end else begin
      bus.mem_en <= 1'b0;
      bus.mem_we <= 1'b0;
    end
  end

  assign vld_p1 = bus.mem_en && !bus.mem_we;

  // Stage p1 -> p2: memory access cycle; mem_rdata is valid while vld_p2 is high
  // Stage p2 -> p3: capture read data into the output register
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p2       <= 1'b0;
      bus.rd_valid <= 1'b0;
      bus.rd_data  <= '0;
    end else begin
      vld_p2       <= vld_p1;
      bus.rd_valid <= vld_p2;
      if (vld_p2) bus.rd_data <= bus.mem_rdata;
    end
  end

`ifdef FB_ARBITER_DROP_CNT_EN
  logic drop;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign drop = bus.wr_req && !push;

  always_ff @(posedge clk) begin
    if (reset)     drop_cnt <= '0;
    else if (drop) drop_cnt <= sat_inc(drop_cnt);
  end
`endif
endmodule

// File: tb/tb_fb_arbiter.sv
// Directed bench for fb_arbiter: read latency, queued writes, priority,
// overflow, full-plus-pop and reset behaviour against a behavioural memory.
module tb_fb_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   chk_cnt = 0;
  int   pass_cnt = 0;
  int   cyc = 0;

  logic [7:0] tb_mem [0:32767];
  int op_we[$], op_addr[$], op_data[$], op_cyc[$];
  int rv_data[$];

  fb_arbiter_if #(.ADDR_W(15), .DATA_W(8), .FIFO_DEPTH(4)) bus ();

`ifdef FB_ARBITER_DROP_CNT_EN
  logic [15:0] drop_cnt;
`endif

  fb_arbiter #(.ADDR_W(15), .DATA_W(8), .FIFO_DEPTH(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus)
`ifdef FB_ARBITER_DROP_CNT_EN
    ,
    .drop_cnt (drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural single-port memory: read data valid the cycle after the strobe
  always @(posedge clk) begin
    if (bus.mem_en === 1'b1) begin
      if (bus.mem_we) tb_mem[bus.mem_addr] = bus.mem_wdata;
      else            bus.mem_rdata <= tb_mem[bus.mem_addr];
    end
  end

  always @(posedge clk) begin
    if (bus.mem_en === 1'b1) begin
      op_we.push_back(int'(bus.mem_we));
      op_addr.push_back(int'(bus.mem_addr));
      op_data.push_back(int'(bus.mem_wdata));
      op_cyc.push_back(cyc);
    end
    if (bus.rd_valid === 1'b1) rv_data.push_back(int'(bus.rd_data));
    cyc = cyc + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    op_we.delete(); op_addr.delete(); op_data.delete(); op_cyc.delete(); rv_data.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1; bus.rd_req = 1'b1; bus.rd_addr = 15'h0123;
    bus.wr_req = 1'b1; bus.wr_addr = 15'h0001; bus.wr_data = 8'h02;
    repeat (3) step();
    chk_cnt++; if (bus.mem_en !== 1'b0) $display("FAIL reset_mem_en got %0h want 0", bus.mem_en); else pass_cnt++;
    chk_cnt++; if (bus.mem_we !== 1'b0) $display("FAIL reset_mem_we got %0h want 0", bus.mem_we); else pass_cnt++;
    chk_cnt++; if (bus.mem_addr !== 15'h0) $display("FAIL reset_mem_addr got %0h want 0", bus.mem_addr); else pass_cnt++;
    chk_cnt++; if (bus.mem_wdata !== 8'h0) $display("FAIL reset_mem_wdata got %0h want 0", bus.mem_wdata); else pass_cnt++;
    chk_cnt++; if (bus.rd_valid !== 1'b0) $display("FAIL reset_rd_valid got %0h want 0", bus.rd_valid); else pass_cnt++;
    chk_cnt++; if (bus.rd_data !== 8'h0) $display("FAIL reset_rd_data got %0h want 0", bus.rd_data); else pass_cnt++;
    chk_cnt++; if (bus.wr_level !== 3'd0) $display("FAIL reset_wr_level got %0d want 0", bus.wr_level); else pass_cnt++;
`ifdef FB_ARBITER_DROP_CNT_EN
    chk_cnt++; if (drop_cnt !== 16'd0) $display("FAIL reset_drop_cnt got %0d want 0", drop_cnt); else pass_cnt++;
`endif
    reset = 1'b0; bus.rd_req = 1'b0; bus.wr_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk_cnt++; if (bus.rd_valid !== 1'b0) $display("FAIL post_reset_rd_valid cyc %0d got %0h want 0", i, bus.rd_valid); else pass_cnt++;
      chk_cnt++; if (bus.mem_en !== 1'b0) $display("FAIL post_reset_mem_en cyc %0d got %0h want 0", i, bus.mem_en); else pass_cnt++;
    end
  endtask

  task automatic test_single_read();
    bus.rd_addr = 15'h0123; bus.rd_req = 1'b1;
    step();
    bus.rd_req = 1'b0;
    chk_cnt++; if (bus.mem_en !== 1'b1) $display("FAIL rd1_mem_en got %0h want 1", bus.mem_en); else pass_cnt++;
    chk_cnt++; if (bus.mem_we !== 1'b0) $display("FAIL rd1_mem_we got %0h want 0", bus.mem_we); else pass_cnt++;
    chk_cnt++; if (bus.mem_addr !== 15'h0123) $display("FAIL rd1_mem_addr got %0h want 123", bus.mem_addr); else pass_cnt++;
    chk_cnt++; if (bus.rd_valid !== 1'b0) $display("FAIL rd1_valid_n1 got %0h want 0", bus.rd_valid); else pass_cnt++;
    step();
    chk_cnt++; if (bus.rd_valid !== 1'b0) $display("FAIL rd1_valid_n2 got %0h want 0", bus.rd_valid); else pass_cnt++;
    step();
    chk_cnt++; if (bus.rd_valid !== 1'b1) $display("FAIL rd1_valid_n3 got %0h want 1", bus.rd_valid); else pass_cnt++;
    chk_cnt++; if (bus.rd_data !== 8'h5A) $display("FAIL rd1_data got %0h want 5a", bus.rd_data); else pass_cnt++;
    step();
    chk_cnt++; if (bus.rd_valid !== 1'b0) $display("FAIL rd1_valid_n4 got %0h want 0", bus.rd_valid); else pass_cnt++;
  endtask

  task automatic test_idle_write();
    bus.wr_addr = 15'h7FFF; bus.wr_data = 8'hC3; bus.wr_req = 1'b1;
    step();
    bus.wr_req = 1'b0;
    chk_cnt++; if (bus.wr_level !== 3'd1) $display("FAIL wr1_level_queued got %0d want 1", bus.wr_level); else pass_cnt++;
    chk_cnt++; if (bus.mem_en !== 1'b0) $display("FAIL wr1_no_bypass mem_en got %0h want 0", bus.mem_en); else pass_cnt++;
    step();
    chk_cnt++; if (bus.mem_en !== 1'b1) $display("FAIL wr1_mem_en got %0h want 1", bus.mem_en); else pass_cnt++;
    chk_cnt++; if (bus.mem_we !== 1'b1) $display("FAIL wr1_mem_we got %0h want 1", bus.mem_we); else pass_cnt++;
    chk_cnt++; if (bus.mem_addr !== 15'h7FFF) $display("FAIL wr1_mem_addr got %0h want 7fff", bus.mem_addr); else pass_cnt++;
    chk_cnt++; if (bus.mem_wdata !== 8'hC3) $display("FAIL wr1_mem_wdata got %0h want c3", bus.mem_wdata); else pass_cnt++;
    chk_cnt++; if (bus.wr_level !== 3'd0) $display("FAIL wr1_level_drained got %0d want 0", bus.wr_level); else pass_cnt++;
    step();
    chk_cnt++; if (bus.mem_en !== 1'b0) $display("FAIL wr1_idle_after got %0h want 0", bus.mem_en); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    clear_logs();
    for (int i = 0; i < 6; i++) tb_mem[15'h0020 + i] = 8'h30 + 8'(i);
    for (int i = 0; i < 6; i++) begin
      bus.rd_req = 1'b1; bus.rd_addr = 15'h0020 + 15'(i);
      bus.wr_req = (i < 3); bus.wr_addr = 15'h0010 + 15'(i); bus.wr_data = 8'hA0 + 8'(i);
      step();
    end
    bus.rd_req = 1'b0; bus.wr_req = 1'b0;
    chk_cnt++; if (bus.wr_level !== 3'd3) $display("FAIL b2b_level got %0d want 3", bus.wr_level); else pass_cnt++;
    repeat (10) step();
    chk_cnt++; if (op_we.size() != 9) $display("FAIL b2b_op_count got %0d want 9", op_we.size()); else pass_cnt++;
    for (int k = 0; k < op_we.size() && k < 9; k++) begin
      chk_cnt++; if (op_we[k] != int'(k >= 6)) $display("FAIL b2b_op_kind idx %0d got %0d want %0d", k, op_we[k], int'(k >= 6)); else pass_cnt++;
      chk_cnt++; if (op_addr[k] != ((k < 6) ? 'h20 + k : 'h10 + k - 6)) $display("FAIL b2b_op_addr idx %0d got %0h want %0h", k, op_addr[k], (k < 6) ? 'h20 + k : 'h10 + k - 6); else pass_cnt++;
      chk_cnt++; if (op_cyc[k] != op_cyc[0] + k) $display("FAIL b2b_op_cycle idx %0d got %0d want %0d", k, op_cyc[k], op_cyc[0] + k); else pass_cnt++;
      if (k >= 6) begin
        chk_cnt++; if (op_data[k] != 'hA0 + k - 6) $display("FAIL b2b_wdata idx %0d got %0h want %0h", k, op_data[k], 'hA0 + k - 6); else pass_cnt++;
      end
    end
    chk_cnt++; if (rv_data.size() != 6) $display("FAIL b2b_rd_count got %0d want 6", rv_data.size()); else pass_cnt++;
    for (int k = 0; k < rv_data.size() && k < 6; k++) begin
      chk_cnt++; if (rv_data[k] != 'h30 + k) $display("FAIL b2b_rd_data idx %0d got %0h want %0h", k, rv_data[k], 'h30 + k); else pass_cnt++;
    end
  endtask

  task automatic test_overflow();
    clear_logs();
    for (int i = 0; i < 8; i++) begin
      bus.rd_req = 1'b1; bus.rd_addr = 15'h0123;
      bus.wr_req = (i < 6); bus.wr_addr = 15'h0040 + 15'(i); bus.wr_data = 8'h50 + 8'(i);
      step();
      if (i == 5) begin
        chk_cnt++; if (bus.wr_level !== 3'd4) $display("FAIL ovf_level_full got %0d want 4", bus.wr_level); else pass_cnt++;
      end
    end
    bus.rd_req = 1'b0; bus.wr_req = 1'b0;
`ifdef FB_ARBITER_DROP_CNT_EN
    chk_cnt++; if (drop_cnt !== 16'd2) $display("FAIL ovf_drop_cnt got %0d want 2", drop_cnt); else pass_cnt++;
`endif
    repeat (8) step();
    chk_cnt++; if (bus.wr_level !== 3'd0) $display("FAIL ovf_level_drained got %0d want 0", bus.wr_level); else pass_cnt++;
    chk_cnt++; if (op_we.size() != 12) $display("FAIL ovf_op_count got %0d want 12", op_we.size()); else pass_cnt++;
    for (int k = 0; k < op_we.size() && k < 12; k++) begin
      chk_cnt++; if (op_we[k] != int'(k >= 8)) $display("FAIL ovf_op_kind idx %0d got %0d want %0d", k, op_we[k], int'(k >= 8)); else pass_cnt++;
      if (k >= 8) begin
        chk_cnt++; if (op_addr[k] != 'h40 + k - 8 || op_data[k] != 'h50 + k - 8) $display("FAIL ovf_write idx %0d got %0h/%0h want %0h/%0h", k, op_addr[k], op_data[k], 'h40 + k - 8, 'h50 + k - 8); else pass_cnt++;
      end
    end
  endtask

  task automatic test_full_pop();
    clear_logs();
    for (int i = 0; i < 4; i++) begin
      bus.rd_req = 1'b1; bus.rd_addr = 15'h0123;
      bus.wr_req = 1'b1; bus.wr_addr = 15'h0060 + 15'(i); bus.wr_data = 8'h70 + 8'(i);
      step();
    end
    chk_cnt++; if (bus.wr_level !== 3'd4) $display("FAIL fp_level_before got %0d want 4", bus.wr_level); else pass_cnt++;
    bus.rd_req = 1'b0; bus.wr_req = 1'b1; bus.wr_addr = 15'h0064; bus.wr_data = 8'h74;
    step();
    bus.wr_req = 1'b0;
    chk_cnt++; if (bus.wr_level !== 3'd4) $display("FAIL fp_level_after got %0d want 4", bus.wr_level); else pass_cnt++;
    chk_cnt++; if (bus.mem_en !== 1'b1 || bus.mem_we !== 1'b1) $display("FAIL fp_write_issue got en=%0h we=%0h want en=1 we=1", bus.mem_en, bus.mem_we); else pass_cnt++;
    chk_cnt++; if (bus.mem_addr !== 15'h0060 || bus.mem_wdata !== 8'h70) $display("FAIL fp_write_head got %0h/%0h want 60/70", bus.mem_addr, bus.mem_wdata); else pass_cnt++;
    repeat (8) step();
    chk_cnt++; if (bus.wr_level !== 3'd0) $display("FAIL fp_level_drained got %0d want 0", bus.wr_level); else pass_cnt++;
    chk_cnt++; if (op_we.size() != 9) $display("FAIL fp_op_count got %0d want 9", op_we.size()); else pass_cnt++;
    for (int k = 4; k < op_we.size() && k < 9; k++) begin
      chk_cnt++; if (op_we[k] != 1 || op_addr[k] != 'h60 + k - 4 || op_data[k] != 'h70 + k - 4) $display("FAIL fp_write idx %0d got we=%0d %0h/%0h want we=1 %0h/%0h", k, op_we[k], op_addr[k], op_data[k], 'h60 + k - 4, 'h70 + k - 4); else pass_cnt++;
    end
`ifdef FB_ARBITER_DROP_CNT_EN
    chk_cnt++; if (drop_cnt !== 16'd2) $display("FAIL fp_drop_cnt got %0d want 2", drop_cnt); else pass_cnt++;
`endif
  endtask

  task automatic test_reset_mid_read();
    bus.rd_addr = 15'h0123; bus.rd_req = 1'b1;
    bus.wr_req = 1'b1; bus.wr_addr = 15'h0011; bus.wr_data = 8'hEE;
    step();
    reset = 1'b1; bus.rd_req = 1'b0; bus.wr_req = 1'b0;
    chk_cnt++; if (bus.mem_en !== 1'b1 || bus.wr_level !== 3'd1) $display("FAIL rst_mid_pre got en=%0h lvl=%0d want en=1 lvl=1", bus.mem_en, bus.wr_level); else pass_cnt++;
    step();
    reset = 1'b0; bus.rd_req = 1'b1; bus.rd_addr = 15'h7FFF;
    chk_cnt++; if (bus.rd_valid !== 1'b0) $display("FAIL rst_mid_valid_n2 got %0h want 0", bus.rd_valid); else pass_cnt++;
    chk_cnt++; if (bus.wr_level !== 3'd0) $display("FAIL rst_mid_level got %0d want 0", bus.wr_level); else pass_cnt++;
    chk_cnt++; if (bus.mem_en !== 1'b0) $display("FAIL rst_mid_mem_en got %0h want 0", bus.mem_en); else pass_cnt++;
`ifdef FB_ARBITER_DROP_CNT_EN
    chk_cnt++; if (drop_cnt !== 16'd0) $display("FAIL rst_mid_drop_cnt got %0d want 0", drop_cnt); else pass_cnt++;
`endif
    step();
    bus.rd_req = 1'b0;
    chk_cnt++; if (bus.rd_valid !== 1'b0) $display("FAIL rst_mid_valid_n3 got %0h want 0", bus.rd_valid); else pass_cnt++;
    chk_cnt++; if (bus.mem_en !== 1'b1 || bus.mem_we !== 1'b0 || bus.mem_addr !== 15'h7FFF) $display("FAIL first_read_issue got en=%0h we=%0h a=%0h want 1/0/7fff", bus.mem_en, bus.mem_we, bus.mem_addr); else pass_cnt++;
    step();
    chk_cnt++; if (bus.rd_valid !== 1'b0) $display("FAIL rst_mid_valid_n4 got %0h want 0", bus.rd_valid); else pass_cnt++;
    chk_cnt++; if (bus.mem_en !== 1'b0 || bus.wr_level !== 3'd0) $display("FAIL rst_mid_flushed got en=%0h lvl=%0d want 0/0", bus.mem_en, bus.wr_level); else pass_cnt++;
    step();
    chk_cnt++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== 8'hC3) $display("FAIL raw_read got v=%0h d=%0h want 1/c3", bus.rd_valid, bus.rd_data); else pass_cnt++;
    step();
    chk_cnt++; if (bus.rd_valid !== 1'b0) $display("FAIL raw_read_single got %0h want 0", bus.rd_valid); else pass_cnt++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.rd_req = 1'b0; bus.rd_addr = '0; bus.wr_req = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    tb_mem[15'h0123] = 8'h5A;
    tb_mem[15'h7FFF] = 8'h00;
    test_reset();
    test_single_read();
    test_idle_write();
    test_back_to_back();
    test_overflow();
    test_full_pop();
    test_reset_mid_read();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule

// File: doc/fb_arbiter.md
FB_ARBITER -- requirements
Module: fb_arbiter

Interface
REQ-001 Parameter ADDR_W, default 15, pixel address width in bits.
REQ-002 Parameter DATA_W, default 8, pixel width in bits.
REQ-003 Parameter FIFO_DEPTH, default 4, write-queue entries; SHALL be a power of two and at least 2.
REQ-004 clk  in  1  single clock; all state SHALL change on its rising edge only.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 rd_req  in  1  scanout read request; single-cycle pulse.
REQ-007 rd_addr  in  ADDR_W  scanout read address, sampled with rd_req.
REQ-008 rd_valid  out  1  single-cycle strobe; rd_data is valid while it is high.
REQ-009 rd_data  out  DATA_W  read pixel.
REQ-010 wr_req  in  1  write pulse from the UART path; no backpressure.
REQ-011 wr_addr  in  ADDR_W  write address, sampled with wr_req.
REQ-012 wr_data  in  DATA_W  write pixel, sampled with wr_req.
REQ-013 wr_level  out  log2(FIFO_DEPTH)+1  current write-queue occupancy.
REQ-014 mem_en  out  1  memory access strobe; registered.
REQ-015 mem_we  out  1  1 = write, 0 = read; registered; meaningful only while mem_en is high.
REQ-016 mem_addr  out  ADDR_W  memory address; registered.
REQ-017 mem_wdata  out  DATA_W  memory write data; registered.
REQ-018 mem_rdata  in  DATA_W  read data, valid the cycle after a read strobe.

Function
REQ-019 The block SHALL share one single-port memory between two requesters: scanout reads and queued writes.
REQ-020 Slot selection each cycle:
- rd_req high: issue a read (absolute priority).
- else, queue non-empty: issue a write from the queue head.
- else: idle, mem_en=0.
REQ-021 Read latency SHALL be fixed:
- rd_req sampled at cycle N -> mem_en/mem_we=0/mem_addr=rd_addr in cycle N+1.
- mem_rdata captured at the end of N+2.
- rd_valid=1 with rd_data in N+3.
REQ-022 Reads SHALL be fully pipelined: rd_req on consecutive cycles yields rd_valid on consecutive cycles, in order.
REQ-023 A write issue SHALL pop the queue head and drive mem_en=1, mem_we=1, mem_addr and mem_wdata in the following cycle.
REQ-024 The write queue SHALL be FIFO-ordered; writes SHALL reach memory in acceptance order.
REQ-025 wr_req SHALL be accepted when occupancy after any same-cycle pop is below FIFO_DEPTH; otherwise the write is dropped and the queue is unchanged.
REQ-026 Simultaneous wr_req and pop on a full queue: accept the new write; occupancy is unchanged.
REQ-027 Simultaneous wr_req on an empty queue with no rd_req: the write is enqueued this cycle and issued no earlier than the next cycle (no bypass).
REQ-028 Pointers SHALL wrap modulo FIFO_DEPTH; wr_level SHALL equal exact occupancy and never exceed FIFO_DEPTH.
REQ-029 A read-after-write to the same address issued after the write reaches memory SHALL return the new data; no hazard checking is required against writes still queued.

Reset
REQ-030 While reset is high: mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, rd_valid=0, rd_data=0, wr_level=0.
REQ-031 Reset mid-operation SHALL flush the queue and discard in-flight reads; no rd_valid SHALL be asserted for requests sampled before or during reset.
REQ-032 Requests on the first cycle after reset deasserts SHALL be serviced normally.

Configuration
REQ-033 Macro FB_ARBITER_DROP_CNT_EN defined: add output drop_cnt (16 bits), a counter incremented per dropped write, saturating at 0xFFFF, cleared by reset.
REQ-034 Macro FB_ARBITER_DROP_CNT_EN undefined: port drop_cnt and its logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-035 Single read: rd_req with rd_addr=0x0123 at cycle N, memory holds 0x5A -> mem_en=1, mem_we=0, mem_addr=0x0123 at N+1; rd_valid=1, rd_data=0x5A at N+3 only.
REQ-036 Idle write: wr_req with wr_addr=0x7FFF, wr_data=0xC3, no reads -> wr_level=1, then one write cycle to 0x7FFF/0xC3, then wr_level=0.
REQ-037 Contention: rd_req held high for 6 cycles while 3 writes are queued -> 6 reads issued back-to-back, then 3 writes in order, 0 dropped.
REQ-038 Overflow (default depth): rd_req held high, 6 wr_req pulses -> wr_level=4 and 2 writes dropped; drop_cnt=2 when FB_ARBITER_DROP_CNT_EN is defined; the 4 writes accepted first reach memory after reads stop.
REQ-039 Full plus pop: queue full, rd_req low, wr_req in the same cycle -> one write issued, new write accepted, wr_level stays 4.
REQ-040 Reset mid-read: rd_req at N, reset high at N+1 -> rd_valid stays 0 through N+4; the queue is empty afterward.
